cpu_bus_capture: RTL and testbench
==================================

CPU_BUS_CAPTURE -- requirements
Module: cpu_bus_capture

Interface
REQ-001 Parameter M2_MIN_HIGH, default 3: minimum synchronized m2-high clocks for a cycle to count as valid.
REQ-002 Parameter FIFO_DEPTH, default 2: number of entries in the write-event queue; fixed at 2.
REQ-003 clk  in  1  system clock, at least 8x m2 frequency; the only clock in the block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m2  in  1  raw CPU phi2, asynchronous to clk.
REQ-006 romsel  in  1  raw /ROMSEL, active low, asynchronous.
REQ-007 cpu_rw_in  in  1  raw CPU R/W; 0 means write.
REQ-008 cpu_addr_in  in  15  raw CPU A14..A0.
REQ-009 cpu_data_in  in  8  raw CPU D7..D0.
REQ-010 wr_valid  out  1  queue head holds a write event.
REQ-011 wr_ready  in  1  consumer (mapper register stage) accepts the head.
REQ-012 wr_addr  out  15  address of the head event.
REQ-013 wr_data  out  8  data of the head event.
REQ-014 wr_rom  out  1  head event hit $8000-$FFFF (romsel was low).
REQ-015 overflow  out  1  sticky flag: a write event was dropped.
REQ-016 overflow_clr  in  1  clears overflow.

Function
REQ-017 m2, romsel and cpu_rw_in SHALL each pass through a 2-flop synchronizer; addr and data SHALL be registered once per clk alongside them.
REQ-018 FSM states: IDLE, HIGH, QUAL. IDLE->HIGH on synced m2=1, with cnt=1; HIGH increments cnt each clk while m2=1; HIGH->QUAL when cnt reaches M2_MIN_HIGH; HIGH->IDLE if m2=0 first (glitch, no event); QUAL->IDLE on m2=0.
REQ-019 In HIGH and QUAL, the block SHALL capture rw, romsel, addr and data each clk into a shadow register, so the shadow holds the last sample taken before the falling edge.
REQ-020 On QUAL->IDLE with shadow rw=0, the block SHALL push {addr, data, ~romsel} into the queue; read cycles SHALL produce no event.
REQ-021 Latency: the event SHALL be visible at wr_valid no later than 1 clk after the FSM leaves QUAL, i.e. 4 clk after the raw m2 fall.
REQ-022 Handshake: a pop SHALL occur when wr_valid & wr_ready are both high; the head outputs SHALL stay stable while wr_valid=1 and wr_ready=0.
REQ-023 A push and a pop in the same clk SHALL both take effect, with the count unchanged.
REQ-024 A push when the queue is full and not popping SHALL drop the new event (the queue keeps the older ones) and set overflow.
REQ-025 overflow SHALL clear on overflow_clr unless a drop occurs in the same clk, in which case it stays 1.
REQ-026 wr_addr, wr_data and wr_rom SHALL be 0 whenever the queue is empty.

Reset
REQ-027 reset SHALL force: FSM=IDLE, cnt=0, synchronizers=0, shadow=0, queue empty, wr_valid=0, wr_addr=0, wr_data=0, wr_rom=0, overflow=0.
REQ-028 A reset asserted mid-cycle, while in HIGH or QUAL, SHALL discard that cycle; after reset releases, capture restarts only on a fresh m2 rise seen from IDLE.
REQ-029 Synchronizers SHALL reset to 0, so a reset released while m2 is high SHALL be treated as a rising edge after 2 clk.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, the event record type {addr[14:0], data[7:0], rom}, and the M2_MIN_HIGH default.
REQ-031 The 2-entry queue SHALL be the sub-module bus_event_fifo (push, pop, full, empty, head); synchronizers and FSM stay in the top.
REQ-032 The GxROM register stage SHALL consume wr_valid/wr_data when wr_rom=1, replacing its posedge-romsel latch.

Verification
REQ-033 Write to $8000 with data 0x31, m2 high for 6 clk, wr_ready=1 -> exactly one wr_valid pulse with wr_addr=0x0000, wr_data=0x31, wr_rom=1.
REQ-034 Read cycle at $C000 -> wr_valid stays 0; m2 glitch of 2 clk high during a write -> no event.
REQ-035 wr_ready=0; writes 0x11, 0x22, 0x33 in sequence -> queue holds 0x11 then 0x22, and overflow=1; after wr_ready=1 the bench pops 0x11 then 0x22, nothing else.
REQ-036 Queue holds 1 entry while a new push and a pop land in the same clk -> count stays 1, and the head becomes the new event.
REQ-037 reset pulsed during QUAL of a write to $6000 with data 0xAA -> no event; the next write to $6000 with data 0x55 -> wr_addr=0x6000, wr_data=0x55, wr_rom=0.
REQ-038 overflow_clr and a drop in the same clk -> overflow stays 1; overflow_clr alone -> overflow=0 the next clk.

Source files
------------

// File: rtl/cpu_bus_capture_pkg.sv
// cpu_bus_capture_pkg: shared FSM state, write-event record and timing default
package cpu_bus_capture_pkg;
  localparam int M2_MIN_HIGH_DEFAULT = 3;
  typedef enum logic [1:0] {IDLE, HIGH, QUAL} cap_state_t;
  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
    logic        rom;
  } bus_event_t;
endpackage

// File: rtl/bus_event_fifo.sv
// bus_event_fifo: small ring-buffer queue of captured bus write events
module bus_event_fifo
  import cpu_bus_capture_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  bus_event_t din,
  output logic       full,
  output logic       empty,
  output bus_event_t head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  bus_event_t mem [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/cpu_bus_capture.sv
// cpu_bus_capture: synchronizes the raw CPU bus and queues qualified write cycles
module cpu_bus_capture
  import cpu_bus_capture_pkg::*;
#(
  parameter int M2_MIN_HIGH = M2_MIN_HIGH_DEFAULT,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m2,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_rom,
  output logic        overflow,
  input  logic        overflow_clr
);
  localparam int CW = $clog2(M2_MIN_HIGH + 1);
  cap_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] m2_q, rs_q, rw_q;
  logic [14:0] addr_q;
  logic [7:0] data_q;
  logic shadow_rw, m2_s, push, pop, full, empty, drop;
  bus_event_t shadow, head;
  assign m2_s = m2_q[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      m2_q <= '0;
      rs_q <= '0;
      rw_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      state <= IDLE;
      cnt <= '0;
      shadow_rw <= 1'b0;
      shadow <= '0;
      overflow <= 1'b0;
    end else begin
      m2_q <= {m2_q[0], m2};
      rs_q <= {rs_q[0], romsel};
      rw_q <= {rw_q[0], cpu_rw_in};
      addr_q <= cpu_addr_in;
      data_q <= cpu_data_in;
      state <= state_nx;
      cnt <= cnt_nx;
      if (state != IDLE && m2_s) begin
        shadow_rw <= rw_q[1];
        shadow <= {addr_q, data_q, ~rs_q[1]};
      end
      overflow <= drop | (overflow & ~overflow_clr);
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    push = 1'b0;
    case (state)
      IDLE: if (m2_s) begin
        state_nx = HIGH;
        cnt_nx = CW'(1);
      end
      HIGH: if (!m2_s) begin
        state_nx = IDLE;
        cnt_nx = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
        state_nx = cnt_nx >= CW'(M2_MIN_HIGH) ? QUAL : HIGH;
      end
      QUAL: if (!m2_s) begin
        state_nx = IDLE;
        cnt_nx = '0;
        push = ~shadow_rw;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign wr_valid = ~empty;
  assign pop = wr_ready & ~empty;
  assign drop = push & full & ~pop;
  assign {wr_addr, wr_data, wr_rom} = head;
  bus_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(shadow),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule

// File: tb/tb_cpu_bus_capture.sv
// tb_cpu_bus_capture: table-driven and sequence checks with an event scoreboard
module tb_cpu_bus_capture;
  logic clk, reset, m2, romsel, cpu_rw_in, wr_valid, wr_ready, wr_rom, overflow, overflow_clr;
  logic [14:0] cpu_addr_in, wr_addr;
  logic [7:0] cpu_data_in, wr_data;
  logic [23:0] cur, prev_head;
  logic [23:0] sb [$];
  logic stall_q;
  int tests, fails, lat;
  typedef struct {
    logic rw;
    logic rs;
    logic [14:0] a;
    logic [7:0] d;
    int hi;
    logic evt;
    logic [14:0] ea;
    logic [7:0] ed;
    logic er;
  } vec_t;
  vec_t v [7];
  cpu_bus_capture dut (
    .clk(clk),
    .reset(reset),
    .m2(m2),
    .romsel(romsel),
    .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_rom(wr_rom),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );
  assign cur = {wr_addr, wr_data, wr_rom};
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_cycle(input logic rw, input logic rs, input logic [14:0] a, input logic [7:0] d,
                           input int hi, input logic clr, input logic rdy_pulse);
    cpu_rw_in = rw;
    romsel = rs;
    cpu_addr_in = a;
    cpu_data_in = d;
    m2 = 1'b1;
    repeat (hi) tick();
    m2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin
        overflow_clr = clr;
        if (rdy_pulse) wr_ready = 1'b1;
      end
      tick();
      if (k == 3) begin
        overflow_clr = 1'b0;
        if (rdy_pulse) wr_ready = 1'b0;
      end
      if (lat < 0 && wr_valid) lat = k;
    end
    romsel = 1'b1;
    cpu_rw_in = 1'b1;
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (stall_q) chk("head_hold", 32'(cur), 32'(prev_head));
      if (wr_valid && wr_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_event: got %h, expected no event", cur);
        end else chk("event", 32'(cur), 32'(sb.pop_front()));
      end
      if (!wr_valid) chk("empty_zero", 32'(cur), 32'h0);
    end
    stall_q = !reset && wr_valid && !wr_ready;
    prev_head = cur;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    v = '{
      '{1'b0, 1'b0, 15'h0000, 8'h31, 6, 1'b1, 15'h0000, 8'h31, 1'b1},
      '{1'b1, 1'b0, 15'h4000, 8'hC0, 6, 1'b0, 15'h0, 8'h0, 1'b0},
      '{1'b0, 1'b0, 15'h0000, 8'h77, 2, 1'b0, 15'h0, 8'h0, 1'b0},
      '{1'b0, 1'b1, 15'h6000, 8'h5A, 3, 1'b1, 15'h6000, 8'h5A, 1'b0},
      '{1'b0, 1'b0, 15'h7FFF, 8'hFF, 4, 1'b1, 15'h7FFF, 8'hFF, 1'b1},
      '{1'b0, 1'b1, 15'h4020, 8'h00, 8, 1'b1, 15'h4020, 8'h00, 1'b0},
      '{1'b1, 1'b1, 15'h6001, 8'h99, 6, 1'b0, 15'h0, 8'h0, 1'b0}
    };
    clk = 0; reset = 1; m2 = 0; romsel = 1; cpu_rw_in = 1; cpu_addr_in = '0; cpu_data_in = '0;
    wr_ready = 1; overflow_clr = 0; tests = 0; fails = 0; lat = -1; stall_q = 0; prev_head = '0;
    repeat (3) tick();
    chk("rst_valid", 32'(wr_valid), 32'h0);
    chk("rst_addr", 32'(wr_addr), 32'h0);
    chk("rst_data", 32'(wr_data), 32'h0);
    chk("rst_rom", 32'(wr_rom), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    reset = 0;
    tick();
    for (int i = 0; i < 7; i++) begin
      if (v[i].evt) sb.push_back({v[i].ea, v[i].ed, v[i].er});
      bus_cycle(v[i].rw, v[i].rs, v[i].a, v[i].d, v[i].hi, 1'b0, 1'b0);
      if (v[i].evt) chk("latency", 32'(lat >= 1 && lat <= 4), 32'h1);
      else chk("no_event", 32'(lat), 32'hFFFF_FFFF);
      chk("drain", 32'(sb.size()), 32'h0);
    end
    wr_ready = 0;
    sb.push_back({15'h0123, 8'h11, 1'b0});
    sb.push_back({15'h0123, 8'h22, 1'b0});
    bus_cycle(1'b0, 1'b1, 15'h0123, 8'h11, 6, 1'b0, 1'b0);
    chk("ovf_head1", 32'(wr_data), 32'h11);
    bus_cycle(1'b0, 1'b1, 15'h0123, 8'h22, 6, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b1, 15'h0123, 8'h33, 6, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_valid", 32'(wr_valid), 32'h1);
    chk("ovf_head", 32'(wr_data), 32'h11);
    wr_ready = 1;
    repeat (4) tick();
    chk("ovf_drain", 32'(sb.size()), 32'h0);
    chk("ovf_empty", 32'(wr_valid), 32'h0);
    overflow_clr = 1;
    tick();
    overflow_clr = 0;
    chk("clr_alone", 32'(overflow), 32'h0);
    wr_ready = 0;
    sb.push_back({15'h1000, 8'hA1, 1'b1});
    sb.push_back({15'h1001, 8'hA2, 1'b1});
    bus_cycle(1'b0, 1'b0, 15'h1000, 8'hA1, 5, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b0, 15'h1001, 8'hA2, 5, 1'b0, 1'b0);
    chk("full_no_ovf", 32'(overflow), 32'h0);
    bus_cycle(1'b0, 1'b0, 15'h1002, 8'hA3, 5, 1'b1, 1'b0);
    chk("clr_with_drop", 32'(overflow), 32'h1);
    wr_ready = 1;
    repeat (4) tick();
    chk("clr_drain", 32'(sb.size()), 32'h0);
    wr_ready = 0;
    sb.push_back({15'h2000, 8'hB1, 1'b0});
    sb.push_back({15'h2001, 8'hB2, 1'b0});
    bus_cycle(1'b0, 1'b1, 15'h2000, 8'hB1, 6, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b1, 15'h2001, 8'hB2, 6, 1'b0, 1'b1);
    chk("pp_valid", 32'(wr_valid), 32'h1);
    chk("pp_head", 32'(cur), 32'({15'h2001, 8'hB2, 1'b0}));
    chk("pp_left", 32'(sb.size()), 32'h1);
    wr_ready = 1;
    tick();
    tick();
    chk("pp_count1", 32'(wr_valid), 32'h0);
    chk("pp_drain", 32'(sb.size()), 32'h0);
    cpu_rw_in = 0; romsel = 1; cpu_addr_in = 15'h6000; cpu_data_in = 8'hAA; m2 = 1;
    repeat (6) tick();
    reset = 1;
    tick();
    reset = 0;
    m2 = 0;
    romsel = 1;
    cpu_rw_in = 1;
    repeat (6) tick();
    chk("rst_discard", 32'(wr_valid), 32'h0);
    sb.push_back({15'h6000, 8'h55, 1'b0});
    bus_cycle(1'b0, 1'b1, 15'h6000, 8'h55, 6, 1'b0, 1'b0);
    chk("rst_next_drain", 32'(sb.size()), 32'h0);
    chk("rst_next_ovf", 32'(overflow), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
